// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch sequencer, instruction memory, decode
// and the next-PC unit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) ();
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr_data;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic                  misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
           fetch_pc, misalign_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
           fetch_pc, misalign_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// holds the fetched instruction for decode and squashes fetches on redirect.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_ctrl #(
  parameter int unsigned           DATA_WIDTH = `DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_HALT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr_pc;
  logic [31:0]           r_instr_data;
  logic                  r_misalign;

  logic w_req_hs;
  logic w_redir_ok;
  logic w_redir_bad;

  assign w_req_hs    = (r_state == ST_FETCH) && bus.imem_req_ready;
  assign w_redir_ok  = bus.redirect_valid && (r_state != ST_HALT) &&
                       (bus.redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = bus.redirect_valid && (r_state != ST_HALT) &&
                       (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // A redirect racing an accepted request or a pending response leaves one
  // response still owed, which DRAIN absorbs; if it lands the same cycle it is
  // absorbed immediately and fetch resumes at the new PC.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FETCH: if (w_req_hs) w_next = w_redir_ok ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (bus.imem_rsp_valid) w_next = w_redir_ok ? ST_FETCH : ST_HOLD;
        else if (w_redir_ok)    w_next = ST_DRAIN;
      end
      ST_HOLD:  if (w_redir_ok || bus.instr_ready) w_next = ST_FETCH;
      ST_DRAIN: if (bus.imem_rsp_valid) w_next = ST_FETCH;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_FETCH;
    endcase
    if (w_redir_bad) w_next = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_instr_pc   <= '0;
      r_instr_data <= '0;
      r_misalign   <= 1'b0;
    end else begin
      if (w_redir_ok)
        r_pc <= bus.redirect_pc;
      else if ((r_state == ST_HOLD) && bus.instr_ready && !bus.redirect_valid)
        r_pc <= r_pc + DATA_WIDTH'(4);

      if ((r_state == ST_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid) begin
        r_instr_data <= bus.imem_rsp_data;
        r_instr_pc   <= r_pc;
      end

      if (w_redir_bad) r_misalign <= 1'b1;
    end
  end

  always_comb begin
    bus.imem_req_valid = (r_state == ST_FETCH);
    bus.imem_req_addr  = r_pc;
    bus.instr_valid    = (r_state == ST_HOLD);
    bus.instr_data     = r_instr_data;
    bus.instr_pc       = r_instr_pc;
    bus.fetch_pc       = r_pc;
    bus.misalign_err   = r_misalign;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the architectural PC register and drives the instruction-memory request/response handshake. It holds one fetched instruction for decode under a valid/ready handshake. It accepts control-flow redirects produced by the next-PC unit after branch/jump resolution, and squashes in-flight fetches on redirect. It sits between the imem port and decode, and is the only writer of the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32, from defines.vh): PC/address width. Instruction width is fixed at 32.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req_valid`  out  1  fetch request present.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  DATA_WIDTH  fetch address (equals `fetch_pc`).
- `imem_rsp_valid`  in  1  response data valid; single-cycle pulse.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  held instruction available to decode.
- `instr_ready`  in  1  decode consumes the instruction this cycle.
- `instr_data`  out  32  held instruction.
- `instr_pc`  out  DATA_WIDTH  PC of the held instruction.
- `redirect_valid`  in  1  take a redirect this cycle.
- `redirect_pc`  in  DATA_WIDTH  target from the next-PC unit.
- `fetch_pc`  out  DATA_WIDTH  current PC register.
- `misalign_err`  out  1  sticky: a redirect target had `[1:0]` != 0.

## Operation
- States: FETCH, WAIT, HOLD, DRAIN, HALT. At most one outstanding imem request.
- FETCH: `imem_req_valid`=1, addr=`fetch_pc`. On handshake (`valid && ready`), go to WAIT.
- WAIT: when `imem_rsp_valid`=1, latch data into `instr_data` and `instr_pc` (the PC of that fetch), then go to HOLD.
- HOLD: `instr_valid`=1; data and PC stay stable. When `instr_ready`=1, set `fetch_pc` to `fetch_pc`+4 (mod 2^DATA_WIDTH, wraps) and go to FETCH.
- DRAIN: waits for the squashed response. On `imem_rsp_valid`=1, discard the data and go to FETCH. `instr_valid` stays 0.
- HALT: all request and valid outputs are 0. Only `rst` exits this state.
- Redirect has priority over all other events in a cycle. `fetch_pc` is loaded with `redirect_pc`, and the next state is chosen as follows:
  - FETCH without a handshake: go to FETCH. The address changes next cycle; this is the only permitted address change while valid is held.
  - FETCH with a handshake in the same cycle: go to DRAIN.
  - WAIT without a response: go to DRAIN.
  - WAIT with a response in the same cycle: discard the response and go to FETCH.
  - HOLD: drop the held instruction, even if `instr_ready`=1 in that cycle, and go to FETCH.
  - DRAIN: stay in DRAIN with the new PC. A response arriving in the same cycle is consumed as the drained one, so go to FETCH.
  - HALT: ignore the redirect.
- If `redirect_pc[1:0]` != 0, do not load `fetch_pc`. Set `misalign_err` and go to HALT; a WAIT or DRAIN request is abandoned.
- `imem_rsp_valid` is ignored in FETCH, HOLD and HALT.

## Timing
- Reset values: state FETCH, `fetch_pc`=RESET_PC, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `misalign_err`=0, `imem_req_valid`=1 in the first cycle after `rst` falls.
- `rst` asserted in any state returns to the reset state on the next edge. In-flight responses are not tracked across reset.
- A response arrives no earlier than the cycle after request acceptance.
- Latency: request accept at cycle N, response at cycle N+k (k≥1), `instr_valid` at N+k+1.
- Best-case throughput is one instruction per 3 cycles (FETCH, WAIT with k=1, HOLD with ready).
- Redirect in cycle N: the request to the new target is presented at N+1 (from FETCH/HOLD), or the cycle after the drained response.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Reset with RESET_PC=0x100, memory k=1, `instr_ready`=1 always → fetches at 0x100, 0x104, 0x108; `instr_valid` every 3rd cycle; `instr_pc` matches each address.
- Backpressure: `instr_ready`=0 for 5 cycles in HOLD → `instr_data` and `instr_pc` stable; no new request; PC advances by 4 only after ready.
- Redirect to 0x200 while in WAIT (k=4) → old response discarded, `instr_valid` never asserted for it; next request address is 0x200.
- Redirect to 0x300 during HOLD with `instr_ready`=1 in the same cycle → instruction not counted as consumed; next request is 0x300, not PC+4.
- Redirect to 0x202 → `misalign_err`=1 on the next cycle, `imem_req_valid`=0 permanently; `rst` clears both and restarts at RESET_PC.
- PC wrap: RESET_PC=0xFFFF_FFFC → after one consumed instruction, the next request address is 0x0000_0000.
